cpu_io_port: RTL and testbench



---
 rtl/cpu_io_pkg.sv | 34 +++
 rtl/io_fifo.sv | 71 +++++++
 rtl/cpu_io_port.sv | 127 ++++++++++++
 tb/tb_cpu_io_port.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// ============================================================================
// cpu_io_pkg : register offsets and status bit layout for the CPU I/O window
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_io_pkg;

  localparam logic [3:0] IO_TXDATA = 4'd0;
  localparam logic [3:0] IO_RXDATA = 4'd1;
  localparam logic [3:0] IO_STATUS = 4'd2;
  localparam logic [3:0] IO_TIMER  = 4'd3;

  localparam int ST_TXFULL  = 0;
  localparam int ST_TXEMPTY = 1;
  localparam int ST_TXOVF   = 2;
  localparam int ST_RXFULL  = 3;

  function automatic logic [7:0] pack_status(input logic rx_full,
                                             input logic tx_ovf,
                                             input logic tx_empty,
                                             input logic tx_full);
    logic [7:0] s;
    s             = 8'h00;
    s[ST_TXFULL]  = tx_full;
    s[ST_TXEMPTY] = tx_empty;
    s[ST_TXOVF]   = tx_ovf;
    s[ST_RXFULL]  = rx_full;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_fifo.sv
// ============================================================================
// io_fifo : synchronous FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle. Rev 1.0
// ============================================================================
`default_nettype none

module io_fifo
  import cpu_io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             accept_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop_ok;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    empty_o  = (cnt_q == '0);
    full_o   = (cnt_q == FULL_CNT);
    pop_ok   = pop_i & ~empty_o;
    accept_o = push_i & (~full_o | pop_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(accept_o);
    cnt_d    = cnt_q;
    if (accept_o & ~pop_ok) begin
      cnt_d = cnt_q + CW'(1);
    end else if (~accept_o & pop_ok) begin
      cnt_d = cnt_q - CW'(1);
    end
    head_o = empty_o ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_o) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_io_port.sv
// ============================================================================
// cpu_io_port : 16-byte memory-mapped I/O window (TX FIFO, RX holding
// register, status, free-running timer) answering like synchronous RAM. Rev 1.0
// ============================================================================
`default_nettype none

module cpu_io_port
  import cpu_io_pkg::*;
#(
  parameter logic [7:0] BASE     = 8'hF0,
  parameter int         TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       rden,
  input  logic       wren,
  output logic [7:0] rdata,
  output logic       hit_q,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  logic       hit, wr, rd;
  logic [3:0] off;
  logic       tx_push, tx_pop, tx_accept, tx_full, tx_empty;
  logic       ovf_clr, tmr_ld, rx_pop, rx_cap;
  logic [7:0] status;

  logic [7:0] rdata_q, rdata_d;
  logic       hit_d;
  logic       ovf_q, ovf_d;
  logic [7:0] timer_q, timer_d;
  logic       rx_full_q, rx_full_d;
  logic [7:0] rx_byte_q, rx_byte_d;

  // A write wins over a read when both strobes are raised together.
  always_comb begin
    hit     = (addr[7:4] == BASE[7:4]);
    off     = addr[3:0];
    wr      = hit & wren;
    rd      = hit & rden & ~wren;
    tx_push = wr & (off == IO_TXDATA);
    ovf_clr = wr & (off == IO_STATUS);
    tmr_ld  = wr & (off == IO_TIMER);
    rx_pop  = rd & (off == IO_RXDATA) & rx_full_q;
    rx_cap  = rx_valid & ~rx_full_q;
    tx_pop  = ~tx_empty & tx_ready;
  end

  io_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (tx_push),
    .data_i   (wdata),
    .pop_i    (tx_pop),
    .head_o   (tx_data),
    .full_o   (tx_full),
    .empty_o  (tx_empty),
    .accept_o (tx_accept)
  );

  always_comb begin
    status  = pack_status(rx_full_q, ovf_q, tx_empty, tx_full);
    hit_d   = rd;
    rdata_d = 8'h00;
    if (rd) begin
      case (off)
        IO_RXDATA: rdata_d = rx_full_q ? rx_byte_q : 8'h00;
        IO_STATUS: rdata_d = status;
        IO_TIMER:  rdata_d = timer_q;
        default:   rdata_d = 8'h00;
      endcase
    end

    ovf_d = ovf_q;
    if (tx_push & ~tx_accept) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    timer_d = tmr_ld ? wdata : timer_q + 8'd1;

    rx_full_d = rx_full_q;
    rx_byte_d = rx_byte_q;
    if (rx_pop) begin
      rx_full_d = 1'b0;
    end else if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= 8'h00;
      hit_q     <= 1'b0;
      ovf_q     <= 1'b0;
      timer_q   <= 8'h00;
      rx_full_q <= 1'b0;
      rx_byte_q <= 8'h00;
    end else begin
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
      ovf_q     <= ovf_d;
      timer_q   <= timer_d;
      rx_full_q <= rx_full_d;
      rx_byte_q <= rx_byte_d;
    end
  end

  assign rdata    = rdata_q;
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_io_port.sv
// ============================================================================
// tb_cpu_io_port : directed scenarios plus randomized traffic for cpu_io_port,
// checked every cycle against a queue-based behavioural model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_cpu_io_port;

  localparam logic [7:0] BASE  = 8'hF0;
  localparam int         DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr, wdata, rx_data;
  logic       rden, wren, tx_ready, rx_valid;
  logic [7:0] rdata, tx_data;
  logic       hit_q, tx_valid, rx_ready;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  cpu_io_port #(.BASE(BASE), .TX_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .rden     (rden),
    .wren     (wren),
    .rdata    (rdata),
    .hit_q    (hit_q),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] mq[$];
  logic [7:0] m_timer, m_rx_byte, m_rdata;
  logic       m_rx_full, m_ovf, m_hit;

  function automatic logic [7:0] m_status();
    return {4'b0, m_rx_full, m_ovf, (mq.size() == 0), (mq.size() == DEPTH)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_timer = 8'h00; m_rx_byte = 8'h00; m_rdata = 8'h00;
      m_rx_full = 1'b0; m_ovf = 1'b0; m_hit = 1'b0;
    end else begin
      automatic bit         in_win = (addr[7:4] == BASE[7:4]);
      automatic logic [3:0] o      = addr[3:0];
      automatic bit         w      = in_win && wren;
      automatic bit         r      = in_win && rden && !wren;
      automatic bit         pop    = (mq.size() > 0) && tx_ready;
      automatic bit         acc    = 1'b0;
      automatic bit         rxf    = m_rx_full;
      m_hit   = r;
      m_rdata = 8'h00;
      if (r) begin
        if (o == 4'd1) m_rdata = rxf ? m_rx_byte : 8'h00;
        else if (o == 4'd2) m_rdata = m_status();
        else if (o == 4'd3) m_rdata = m_timer;
      end
      if (w && o == 4'd0) begin
        if (mq.size() < DEPTH || pop) acc = 1'b1;
        else m_ovf = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(wdata);
      if (w && o == 4'd2) m_ovf = 1'b0;
      m_timer = (w && o == 4'd3) ? wdata : m_timer + 8'd1;
      if (r && o == 4'd1 && rxf) m_rx_full = 1'b0;
      else if (rx_valid && !rxf) begin
        m_rx_full = 1'b1;
        m_rx_byte = rx_data;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rdata",    rdata,            m_rdata);
      check("hit_q",    {7'b0, hit_q},    {7'b0, m_hit});
      check("tx_valid", {7'b0, tx_valid}, {7'b0, mq.size() != 0});
      check("tx_data",  tx_data,          (mq.size() != 0) ? mq[0] : 8'h00);
      check("rx_ready", {7'b0, rx_ready}, {7'b0, !m_rx_full});
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus(input logic [7:0] a, input logic [7:0] d, input logic r, input logic w);
    addr = a; wdata = d; rden = r; wren = w;
    @(negedge clk);
    rden = 1'b0; wren = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = 8'h00; wdata = 8'h00; rden = 1'b0; wren = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    chk_en = 1'b1;
    check("reset_rdata", rdata, 8'h00);
    check("reset_txv", {7'b0, tx_valid}, 8'h00);
    check("reset_txd", tx_data, 8'h00);
    rst = 1'b0;

    // Reset then idle
    idle(5);
    bus(8'hF3, 8'h00, 1'b1, 1'b0);
    check("timer5", rdata, 8'h05);
    check("timer5_hit", {7'b0, hit_q}, 8'h01);
    check("idle_rxrdy", {7'b0, rx_ready}, 8'h01);
    bus(8'hF2, 8'h00, 1'b1, 1'b0);
    check("idle_status", rdata, 8'h02);

    // TX burst with consumer stalled
    foreach (mq[i]) ; // model queue is empty here
    bus(8'hF0, 8'h11, 1'b0, 1'b1);
    bus(8'hF0, 8'h22, 1'b0, 1'b1);
    bus(8'hF0, 8'h33, 1'b0, 1'b1);
    bus(8'hF0, 8'h44, 1'b0, 1'b1);
    bus(8'hF0, 8'h55, 1'b0, 1'b1);
    bus(8'hF2, 8'h00, 1'b1, 1'b0);
    check("burst_status", rdata, 8'h05);
    tx_ready = 1'b1;
    check("drain0", tx_data, 8'h11);
    idle(1); check("drain1", tx_data, 8'h22);
    idle(1); check("drain2", tx_data, 8'h33);
    idle(1); check("drain3", tx_data, 8'h44);
    idle(1); check("drain_empty", {7'b0, tx_valid}, 8'h00);
    tx_ready = 1'b0;
    bus(8'hF2, 8'h00, 1'b0, 1'b1);
    bus(8'hF2, 8'h00, 1'b1, 1'b0);
    check("ovf_clear", rdata, 8'h02);

    // RX path
    rx_valid = 1'b1; rx_data = 8'hA5;
    idle(1);
    rx_valid = 1'b0;
    check("rx_ready_low", {7'b0, rx_ready}, 8'h00);
    bus(8'hF2, 8'h00, 1'b1, 1'b0);
    check("rx_status", rdata, 8'h0A);
    bus(8'hF1, 8'h00, 1'b1, 1'b0);
    check("rx_read", rdata, 8'hA5);
    check("rx_ready_high", {7'b0, rx_ready}, 8'h01);
    bus(8'hF1, 8'h00, 1'b1, 1'b0);
    check("rx_read_empty", rdata, 8'h00);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) bus(8'hF0, 8'(8'h60 + i), 1'b0, 1'b1);
    tx_ready = 1'b1;
    bus(8'hF0, 8'h99, 1'b0, 1'b1);
    tx_ready = 1'b0;
    bus(8'hF2, 8'h00, 1'b1, 1'b0);
    check("full_pushpop", rdata, 8'h01);
    tx_ready = 1'b1;
    idle(DEPTH + 1);
    tx_ready = 1'b0;

    // Timer wrap and window edges
    bus(8'hF3, 8'hFE, 1'b0, 1'b1);
    idle(1);
    bus(8'hF3, 8'h00, 1'b1, 1'b0);
    check("timer_ff", rdata, 8'hFF);
    bus(8'hF3, 8'h00, 1'b1, 1'b0);
    check("timer_wrap", rdata, 8'h00);
    bus(8'hFC, 8'h00, 1'b1, 1'b0);
    check("unused_off", rdata, 8'h00);
    check("unused_hit", {7'b0, hit_q}, 8'h01);
    bus(8'hEF, 8'h00, 1'b1, 1'b0);
    check("outside_hit", {7'b0, hit_q}, 8'h00);
    bus(8'hF0, 8'h7E, 1'b1, 1'b1);
    check("rdwr_hit", {7'b0, hit_q}, 8'h00);
    check("rdwr_push", tx_data, 8'h7E);

    // Reset mid-operation
    bus(8'hF0, 8'h01, 1'b0, 1'b1);
    bus(8'hF0, 8'h02, 1'b0, 1'b1);
    rx_valid = 1'b1; rx_data = 8'h3C;
    idle(1);
    rx_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_txv", {7'b0, tx_valid}, 8'h00);
    check("rst_rxrdy", {7'b0, rx_ready}, 8'h01);
    bus(8'hF2, 8'h00, 1'b1, 1'b0);
    check("rst_status", rdata, 8'h02);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) addr = {4'hF, 4'($urandom_range(0, 5))};
      else addr = 8'($urandom);
      wdata    = 8'($urandom);
      rden     = 1'($urandom);
      wren     = ($urandom_range(0, 2) == 0);
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0; rden = 1'b0; wren = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
